// File: rtl/genius_seq_if.sv
// genius_seq_if -- signal bundle between the Genius sequence controller and
// its surroundings (player buttons, sequence ROM, LEDs, status).
//   iniciar     : start/restart request (to controller)
//   botoes      : player buttons, one bit per colour (to controller)
//   rom_data    : synchronous ROM read data (to controller)
//   rom_address : registered ROM address (from controller)
//   leds        : colour LEDs, lit only while showing (from controller)
//   rodada      : current round index (from controller)
//   jogada_ok   : one-cycle pulse per correct press (from controller)
//   ganhou      : game won level (from controller)
//   perdeu      : game lost level (from controller)
//   estado_db   : debug state code (from controller)
interface genius_seq_if;
    logic       iniciar;
    logic [3:0] botoes;
    logic [3:0] rom_data;
    logic [3:0] rom_address;
    logic [3:0] leds;
    logic [3:0] rodada;
    logic       jogada_ok;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] estado_db;

    modport master (
        output iniciar, botoes, rom_data,
        input  rom_address, leds, rodada, jogada_ok, ganhou, perdeu, estado_db
    );

    modport slave (
        input  iniciar, botoes, rom_data,
        output rom_address, leds, rodada, jogada_ok, ganhou, perdeu, estado_db
    );
endinterface

// File: rtl/genius_seq_ctrl.sv
// genius_seq_ctrl -- sequence controller for a Simon/Genius memory game.
// Each round r shows ROM steps 0..r on the LEDs, then waits for the player to
// repeat them on the buttons. Sixteen rounds complete the game.
// Ports:
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : genius_seq_if.slave (iniciar, botoes, rom_data in;
//           rom_address, leds, rodada, jogada_ok, ganhou, perdeu, estado_db out)
module genius_seq_ctrl #(
    parameter int unsigned SHOW_CYCLES    = 500,
    parameter int unsigned GAP_CYCLES     = 250,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic        clock,
    input  logic        reset,
    genius_seq_if.slave bus
);

    localparam int unsigned MAX_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // Encodings double as the estado_db debug code.
    typedef enum logic [3:0] {
        IDLE      = 4'h0,
        FETCH_S   = 4'h2,
        LOAD_S    = 4'h3,
        SHOW      = 4'h4,
        GAP       = 4'h5,
        FETCH_P   = 4'h6,
        LOAD_P    = 4'h7,
        WAIT_PLAY = 4'h8,
        RELEASE   = 4'h9,
        NEXT      = 4'hA,
        WIN       = 4'hE,
        LOSE      = 4'hF
    } state_t;

    state_t        state, state_n;
    logic [3:0]    step, step_n;
    logic [3:0]    round, round_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    addr, addr_n;
    logic [3:0]    expected, expected_n;
    logic          ok, ok_n;
    logic [3:0]    prev_b;
    logic          press;

    // A press is an edge from all-released to anything pressed, so a button
    // still held from earlier never counts until it is released.
    assign press = (bus.botoes != 4'b0000) && (prev_b == 4'b0000);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            round    <= '0;
            cnt      <= '0;
            addr     <= '0;
            expected <= '0;
            ok       <= 1'b0;
            prev_b   <= '0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            round    <= round_n;
            cnt      <= cnt_n;
            addr     <= addr_n;
            expected <= expected_n;
            ok       <= ok_n;
            prev_b   <= bus.botoes;
        end
    end

    // The shared counter defaults to clear, so every timed state enters at 0;
    // a timed state only increments while it stays, so it never wraps.
    always_comb begin
        state_n    = state;
        step_n     = step;
        round_n    = round;
        cnt_n      = '0;
        addr_n     = addr;
        expected_n = expected;
        ok_n       = 1'b0;

        case (state)
            IDLE, WIN, LOSE: begin
                if (bus.iniciar) begin
                    round_n = '0;
                    step_n  = '0;
                    addr_n  = '0;
                    state_n = FETCH_S;
                end
            end

            FETCH_S: state_n = LOAD_S;

            LOAD_S: begin
                expected_n = bus.rom_data;
                state_n    = SHOW;
            end

            SHOW: begin
                if (cnt == SHOW_LAST) state_n = GAP;
                else                  cnt_n   = cnt + CNT_ONE;
            end

            GAP: begin
                if (cnt == GAP_LAST) begin
                    if (step < round) begin
                        step_n  = step + 4'd1;
                        addr_n  = step + 4'd1;
                        state_n = FETCH_S;
                    end else begin
                        step_n  = '0;
                        addr_n  = '0;
                        state_n = FETCH_P;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end

            FETCH_P: state_n = LOAD_P;

            LOAD_P: begin
                expected_n = bus.rom_data;
                state_n    = WAIT_PLAY;
            end

            WAIT_PLAY: begin
                if (press) begin
                    if (bus.botoes == expected) begin
                        ok_n    = 1'b1;
                        state_n = RELEASE;
                    end else begin
                        state_n = LOSE;
                    end
                end else if (cnt == TO_LAST) begin
                    state_n = LOSE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end

            RELEASE: begin
                if (bus.botoes == 4'b0000) begin
                    if (step < round) begin
                        step_n  = step + 4'd1;
                        addr_n  = step + 4'd1;
                        state_n = FETCH_P;
                    end else begin
                        state_n = NEXT;
                    end
                end
            end

            NEXT: begin
                if (round == 4'hF) begin
                    state_n = WIN;
                end else begin
                    round_n = round + 4'd1;
                    step_n  = '0;
                    addr_n  = '0;
                    state_n = FETCH_S;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.rom_address = addr;
    assign bus.leds        = (state == SHOW) ? expected : 4'b0000;
    assign bus.rodada      = round;
    assign bus.jogada_ok   = ok;
    assign bus.ganhou      = (state == WIN);
    assign bus.perdeu      = (state == LOSE);
    assign bus.estado_db   = state;

endmodule

// File: tb/tb_genius_seq_ctrl.sv
// tb_genius_seq_ctrl -- directed bench for genius_seq_ctrl with a procedural
// game model (rounds/steps as nested loops) compared every cycle at negedge.
module tb_genius_seq_ctrl;
    localparam int unsigned SHOW = 4;
    localparam int unsigned GAP  = 2;
    localparam int unsigned TOUT = 20;

    localparam logic [3:0] SEQ_EST  [11] = '{4'h2, 4'h3, 4'h4, 4'h4, 4'h4, 4'h4, 4'h5, 4'h5, 4'h6, 4'h7, 4'h8};
    localparam logic [3:0] SEQ_LED  [11] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    localparam logic [3:0] SEQ_SHOW [14] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0,
                                             4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    genius_seq_if bus();

    genius_seq_ctrl #(
        .SHOW_CYCLES   (SHOW),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Synchronous 16x4 ROM: 0001,0010,0100,1000 repeating.
    logic [3:0] rom [16];
    initial for (int k = 0; k < 16; k++) rom[k] = 4'(1 << (k % 4));
    always @(posedge clock) bus.rom_data <= rom[bus.rom_address];

    int errors = 0;
    int checks = 0;
    int ok_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_estado = 4'h0, m_leds = 4'h0, m_rodada = 4'h0, m_addr = 4'h0;
    logic       m_ok = 1'b0, m_g = 1'b0, m_p = 1'b0;
    logic [3:0] m_prevb = 4'h0;
    bit         m_press = 1'b0;
    bit         ab = 1'b0;
    bit         model_valid = 1'b0;

    task automatic tick();
        @(posedge clock);
        m_ok = 1'b0;
        if (reset === 1'b1) begin
            ab          = 1'b1;
            model_valid = 1'b1;
            m_press     = 1'b0;
            m_prevb     = 4'h0;
        end else begin
            m_press = (bus.botoes != 4'h0) && (m_prevb == 4'h0);
            m_prevb = bus.botoes;
        end
    endtask

    task automatic set_out(input logic [3:0] st);
        m_estado = st;
        m_leds   = 4'h0;
        m_g      = (st == 4'hE);
        m_p      = (st == 4'hF);
    endtask

    task automatic set_idle();
        set_out(4'h0);
        m_rodada = 4'h0;
        m_addr   = 4'h0;
        m_ok     = 1'b0;
    endtask

    // One whole game from the edge that accepted iniciar; returns on LOSE,
    // WIN or a reset edge (ab set).
    task automatic play();
        bit hit;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i <= r; i++) begin
                set_out(4'h2); m_addr = 4'(i); m_rodada = 4'(r);
                tick(); if (ab) return;
                set_out(4'h3);
                tick(); if (ab) return;
                for (int k = 0; k < int'(SHOW); k++) begin
                    set_out(4'h4); m_leds = rom[i];
                    tick(); if (ab) return;
                end
                for (int k = 0; k < int'(GAP); k++) begin
                    set_out(4'h5);
                    tick(); if (ab) return;
                end
            end
            for (int i = 0; i <= r; i++) begin
                set_out(4'h6); m_addr = 4'(i);
                tick(); if (ab) return;
                set_out(4'h7);
                tick(); if (ab) return;
                hit = 1'b0;
                for (int k = 0; k < int'(TOUT); k++) begin
                    set_out(4'h8);
                    tick(); if (ab) return;
                    if (m_press) begin hit = 1'b1; break; end
                end
                if (!hit || bus.botoes != rom[i]) begin
                    set_out(4'hF);
                    return;
                end
                set_out(4'h9); m_ok = 1'b1;
                forever begin
                    tick(); if (ab) return;
                    if (bus.botoes == 4'h0) break;
                    set_out(4'h9);
                end
            end
            set_out(4'hA);
            tick(); if (ab) return;
        end
        set_out(4'hE);
    endtask

    initial begin : model
        set_idle();
        forever begin
            tick();
            if (ab) begin
                ab = 1'b0;
                set_idle();
            end else if (bus.iniciar === 1'b1) begin
                play();
                if (ab) begin
                    ab = 1'b0;
                    set_idle();
                end
            end
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            chk("estado_db",   bus.estado_db,   m_estado);
            chk("leds",        bus.leds,        m_leds);
            chk("rodada",      bus.rodada,      m_rodada);
            chk("rom_address", bus.rom_address, m_addr);
            chk("jogada_ok",   bus.jogada_ok,   m_ok);
            chk("ganhou",      bus.ganhou,      m_g);
            chk("perdeu",      bus.perdeu,      m_p);
            if (bus.jogada_ok === 1'b1) ok_pulses++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_state(input logic [3:0] code, input int limit, input string name);
        bit found = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clock);
            if (bus.estado_db === code) begin found = 1'b1; break; end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out, estado_db %0h required %0h", name, bus.estado_db, code);
        end
    endtask

    task automatic press(input logic [3:0] pat, input int hold);
        @(posedge clock); #2 bus.botoes = pat;
        repeat (hold) @(posedge clock);
        #2 bus.botoes = 4'h0;
    endtask

    task automatic pulse_start();
        @(posedge clock); #2 bus.iniciar = 1'b1;
        @(posedge clock); #2 bus.iniciar = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int n;
        bus.iniciar = 1'b0;
        bus.botoes  = 4'h0;
        reset       = 1'b1;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("reset estado_db",   bus.estado_db,   4'h0);
        chk("reset leds",        bus.leds,        4'h0);
        chk("reset rom_address", bus.rom_address, 4'h0);
        chk("reset rodada",      bus.rodada,      4'h0);
        chk("reset flags",       {bus.jogada_ok, bus.ganhou, bus.perdeu}, 3'b000);

        // First show: one step, then into the player phase.
        pulse_start();
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            chk("start seq estado", bus.estado_db, SEQ_EST[k]);
            chk("start seq leds",   bus.leds,      SEQ_LED[k]);
            chk("model start seq",  m_estado,      SEQ_EST[k]);
        end

        // Round 0: correct press held for 3 cycles.
        ok_pulses = 0;
        press(4'h1, 3);
        wait_state(4'h4, 40, "round1 show");
        chk("round0 jogada_ok pulses", ok_pulses, 1);
        chk("rodada after round0",     bus.rodada, 4'h1);
        chk("round1 show seq", bus.leds, SEQ_SHOW[0]);
        for (int k = 1; k < 14; k++) begin
            @(negedge clock);
            chk("round1 show seq", bus.leds, SEQ_SHOW[k]);
        end

        // Round 1: wrong second press.
        wait_state(4'h8, 40, "round1 step0 wait");
        press(4'h1, 1);
        wait_state(4'h8, 40, "round1 step1 wait");
        press(4'h4, 1);
        @(negedge clock);
        chk("wrong press perdeu", bus.perdeu,    1'b1);
        chk("wrong press estado", bus.estado_db, 4'hF);
        chk("wrong press leds",   bus.leds,      4'h0);
        repeat (10) @(negedge clock);
        chk("lose holds perdeu", bus.perdeu, 1'b1);
        chk("lose holds rodada", bus.rodada, 4'h1);
        pulse_start();
        @(negedge clock);
        chk("restart perdeu", bus.perdeu,    1'b0);
        chk("restart rodada", bus.rodada,    4'h0);
        chk("restart estado", bus.estado_db, 4'h2);

        // Button held from before the player phase never counts.
        bus.botoes = 4'h1;
        wait_state(4'h8, 40, "held wait");
        n = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (bus.estado_db !== 4'h8) break;
            n++;
        end
        chk("held button timeout cycles", n, 20);
        chk("held button lose", bus.estado_db, 4'hF);
        bus.botoes = 4'h0;

        // Full correct game.
        ok_pulses = 0;
        pulse_start();
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i <= r; i++) begin
                wait_state(4'h8, 200, "game wait");
                press(4'(1 << (i % 4)), 1);
            end
        end
        wait_state(4'hE, 50, "win");
        chk("game jogada_ok pulses", ok_pulses, 136);
        chk("win ganhou", bus.ganhou,    1'b1);
        chk("win rodada", bus.rodada,    4'hF);
        chk("win estado", bus.estado_db, 4'hE);
        chk("model win",  m_estado,      4'hE);

        // Reset in the second SHOW cycle of round 1 step 1.
        pulse_start();
        wait_state(4'h8, 40, "replay wait");
        press(4'h1, 1);
        wait_state(4'h4, 40, "replay r1 s0 show");
        wait_state(4'h5, 40, "replay r1 s0 gap");
        wait_state(4'h4, 40, "replay r1 s1 show");
        chk("step1 rom_address", bus.rom_address, 4'h1);
        chk("step1 leds",        bus.leds,        4'h2);
        @(posedge clock); #2 reset = 1'b1;
        @(posedge clock); #2 reset = 1'b0;
        @(negedge clock);
        chk("midshow reset leds",        bus.leds,        4'h0);
        chk("midshow reset estado",      bus.estado_db,   4'h0);
        chk("midshow reset rom_address", bus.rom_address, 4'h0);
        pulse_start();
        wait_state(4'h4, 40, "after reset show");
        chk("replay leds",        bus.leds,        4'h1);
        chk("replay rom_address", bus.rom_address, 4'h0);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/genius_seq_ctrl.md
GENIUS_SEQ_CTRL -- requirements
Module: genius_seq_ctrl

Interface
REQ-001 Parameter SHOW_CYCLES, default 500: number of cycles each sequence LED stays lit.
REQ-002 Parameter GAP_CYCLES, default 250: number of dark cycles after each shown LED.
REQ-003 Parameter TIMEOUT_CYCLES, default 5000: maximum number of cycles to wait for a player press.
REQ-004 Port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port iniciar, input, 1 bit: start or restart request, sampled only in IDLE, WIN or LOSE.
REQ-007 Port botoes, input, 4 bits: player buttons, one bit per colour, level-sensitive.
REQ-008 Port rom_address, output, 4 bits: registered address to the synchronous 16x4 sequence ROM.
REQ-009 Port rom_data, input, 4 bits: ROM output, valid in the second cycle after rom_address changes (one-edge ROM latency).
REQ-010 Port leds, output, 4 bits: colour LEDs driven during the show phase.
REQ-011 Port rodada, output, 4 bits: current round index r, 0..15; round r shows r+1 steps.
REQ-012 Port jogada_ok, output, 1 bit: one-cycle pulse on each correct press.
REQ-013 Port ganhou, output, 1 bit: level, high in WIN.
REQ-014 Port perdeu, output, 1 bit: level, high in LOSE.
REQ-015 Port estado_db, output, 4 bits: state code for debug/7-segment display.

Function
REQ-016 FSM states and estado_db codes: IDLE=0, FETCH_S=2, LOAD_S=3, SHOW=4, GAP=5, FETCH_P=6, LOAD_P=7, WAIT_PLAY=8, RELEASE=9, NEXT=A, WIN=E, LOSE=F.
REQ-017 Internal step index i (4 bits) selects the step; rom_address = i, updated only on entry to FETCH_S/FETCH_P.
REQ-018 IDLE, WIN and LOSE on iniciar=1: clear r and i to 0, clear ganhou/perdeu, go to FETCH_S.
REQ-019 FETCH_S and FETCH_P last exactly 1 cycle; LOAD_S and LOAD_P last exactly 1 cycle and capture rom_data into an expected register at the end of that cycle.
REQ-020 SHOW: leds = expected for exactly SHOW_CYCLES cycles; then GAP.
REQ-021 GAP: leds = 0000 for exactly GAP_CYCLES cycles. On exit, if i<r: i<=i+1 and go to FETCH_S; if i==r: i<=0 and go to FETCH_P.
REQ-022 leds SHALL be 0000 in every state except SHOW.
REQ-023 Press detection: a press is the first cycle with botoes!=0 whose registered previous value was 0000; a button held on entry to WAIT_PLAY is not a press until released and re-pressed.
REQ-024 Presses outside WAIT_PLAY are ignored.
REQ-025 WAIT_PLAY, correct press (botoes == expected, exact 4-bit match): assert jogada_ok in the next cycle and go to RELEASE.
REQ-026 WAIT_PLAY, any other pattern pressed, including multiple bits set: go to LOSE.
REQ-027 WAIT_PLAY timeout: the counter clears on entry; if no press occurs within TIMEOUT_CYCLES cycles, go to LOSE.
REQ-028 RELEASE waits, with no timeout, until botoes==0000. Then: if i<r, i<=i+1 and go to FETCH_P; if i==r, go to NEXT.
REQ-029 NEXT, 1 cycle: if r==15 go to WIN; else r<=r+1, i<=0, go to FETCH_S. r never wraps.
REQ-030 WIN and LOSE hold their outputs, rodada included, until iniciar or reset; iniciar in any other state is ignored.
REQ-031 All counters saturate or clear at state entry and never wrap within a state.

Reset
REQ-032 reset=1 at a rising edge, in any state including mid-SHOW or mid-WAIT_PLAY, forces in the next cycle: state IDLE, leds=0000, rom_address=0, rodada=0, jogada_ok=0, ganhou=0, perdeu=0, estado_db=0, i=0, all counters 0, previous-botoes register 0000.
REQ-033 reset takes priority over iniciar and botoes in the same cycle.

Verification
The bench uses SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20, and a synchronous ROM model with contents 0001,0010,0100,1000,... .
REQ-034 Reset, then a 1-cycle iniciar pulse -> FETCH_S, LOAD_S, then leds=0001 for exactly 4 cycles, then 0000 for 2 cycles, then estado_db=8.
REQ-035 Round 0, press botoes=0001 for 3 cycles then release -> one jogada_ok pulse, rodada=1, leds show 0001 then 0010 (4 cycles each, with a 2-cycle gap).
REQ-036 Round 1, second press 0100 when 0010 is expected -> perdeu=1, estado_db=F, leds=0000; both hold until iniciar, which clears perdeu and restarts at rodada=0.
REQ-037 botoes held at 0001 from before WAIT_PLAY entry and never released -> no press detected, LOSE after 20 cycles.
REQ-038 A full 16-round correct game -> 136 jogada_ok pulses, ganhou=1, rodada=15, estado_db=E.
REQ-039 reset asserted during the 2nd SHOW cycle -> next cycle leds=0000, estado_db=0, rom_address=0; a later iniciar replays from step 0.
